// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

endpackage

// File: rtl/parity_acc.sv
// Running XOR of received bits; load starts a new frame, clear empties it after completion.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  input  logic d,
  output logic q
);

  // load wins over clear so a frame restart in the same cycle is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= 1'b0;
    else if (load)  q <= d;
    else if (clear) q <= 1'b0;
    else if (en)    q <= q ^ d;
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises LSB-first frames of DATA_W data bits plus one parity bit and flags parity errors.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ODD    = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              par_err,
  output logic              out_valid,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned CW    = $clog2(DATA_W + 1);
  localparam logic        SENSE = (ODD == PAR_ODD);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              acc;
  logic              start, collect, complete, perr;

  always_comb begin
    start    = bit_valid & sof;
    collect  = bit_valid & ~sof & (state == DATA);
    complete = bit_valid & ~sof & (state == PAR);
    perr     = acc ^ bit_in ^ SENSE;
  end

  parity_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clear (complete),
    .load  (start),
    .en    (collect),
    .d     (bit_in),
    .q     (acc)
  );

  // Bits enter at the MSB and shift down, so after DATA_W shifts bit 0 sits at [0]
  // and any leftover bits from an aborted frame have been flushed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      par_err     <= 1'b0;
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
      err_count   <= '0;
    end else begin
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
      if (start) begin
        frame_abort <= (state != IDLE);
        shift_reg   <= {bit_in, shift_reg[DATA_W-1:1]};
        cnt         <= CW'(1);
        state       <= DATA;
      end else if (collect) begin
        shift_reg <= {bit_in, shift_reg[DATA_W-1:1]};
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(DATA_W - 1)) state <= PAR;
      end else if (complete) begin
        data_out  <= shift_reg;
        par_err   <= perr;
        out_valid <= 1'b1;
        if (perr && (err_count != '1)) err_count <= err_count + CNT_W'(1);
        cnt       <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: even and odd instances share one serial stream.
module tb_parity_frame_checker;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst, bit_in, bit_valid, sof;
  logic [DW-1:0] data_e, data_o;
  logic          perr_e, perr_o, ov_e, ov_o, ab_e, ab_o;
  logic [7:0]    cnt_e, cnt_o;

  parity_frame_checker #(.DATA_W(DW), .ODD(0), .CNT_W(8)) dut_e (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_e), .par_err(perr_e), .out_valid(ov_e), .frame_abort(ab_e), .err_count(cnt_e));

  parity_frame_checker #(.DATA_W(DW), .ODD(1), .CNT_W(8)) dut_o (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_o), .par_err(perr_o), .out_valid(ov_o), .frame_abort(ab_o), .err_count(cnt_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe_even;
    logic          pe_odd;
  } exp_t;

  exp_t        sb[$];
  longint      vtimes[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned exp_cnt_e = 0, exp_cnt_o = 0;
  int unsigned aborts = 0, valids = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every completed frame pops one expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (ov_e || ov_o) begin
        chk("ov_match", {ov_e, ov_o}, 2'b11);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          if (e.pe_even && exp_cnt_e < 255) exp_cnt_e++;
          if (e.pe_odd  && exp_cnt_o < 255) exp_cnt_o++;
          chk("data_e", data_e, e.data);
          chk("data_o", data_o, e.data);
          chk("perr_e", perr_e, e.pe_even);
          chk("perr_o", perr_o, e.pe_odd);
          chk("cnt_e", cnt_e, exp_cnt_e);
          chk("cnt_o", cnt_o, exp_cnt_o);
        end
        valids++;
        vtimes.push_back($time);
      end
      if (ab_e || ab_o) begin
        aborts++;
        chk("abort_match", {ab_e, ab_o}, 2'b11);
        chk("abort_vs_valid", ov_e | ov_o, 0);
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    bit_in = b; sof = s; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) begin
      bit_in = $urandom_range(0, 1); sof = $urandom_range(0, 1);
      @(posedge clk); #1;
      sof = 1'b0; bit_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input int unsigned gmax);
    exp_t e;
    for (int unsigned i = 0; i < DW; i++) begin
      send_bit(d[i], i == 0);
      gap($urandom_range(0, gmax));
    end
    e.data    = d;
    e.pe_even = (^d) ^ p;
    e.pe_odd  = ~((^d) ^ p);
    sb.push_back(e);
    send_bit(p, 1'b0);
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, {data_e, data_o}, 0);
    chk({tag, "_flags"}, {perr_e, perr_o, ov_e, ov_o, ab_e, ab_o}, 0);
    chk({tag, "_cnt"}, {cnt_e, cnt_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, v0;
    logic [DW-1:0] d;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xA5 good and bad even parity; 0x07 for odd-sense decisions
    send_frame(8'hA5, 1'b0, 0); drain();
    chk("a5_data", data_e, 8'hA5);
    chk("a5_perr", perr_e, 0);
    chk("a5_cnt", cnt_e, 0);
    send_frame(8'hA5, 1'b1, 0); drain();
    chk("a5_bad_perr", perr_e, 1);
    chk("a5_bad_cnt", cnt_e, 1);
    send_frame(8'h07, 1'b0, 0); drain();
    chk("odd07_p0", perr_o, 0);
    send_frame(8'h07, 1'b1, 0); drain();
    chk("odd07_p1", perr_o, 1);

    // Abort: 4 bits of a frame then a fresh sof with 0x3C
    a0 = aborts; v0 = valids;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 0); drain();
    chk("abort_count", aborts - a0, 1);
    chk("abort_valids", valids - v0, 1);
    chk("abort_data", data_e, 8'h3C);
    chk("abort_perr", perr_e, 0);

    // Abort during the parity-wait state
    a0 = aborts;
    for (int unsigned i = 0; i < DW; i++) send_bit(1'b1, i == 0);
    send_frame(8'h5A, 1'b1, 0); drain();
    chk("abort_par_count", aborts - a0, 1);

    // Random gaps with random sof/bit_in noise while bit_valid is low
    for (int unsigned f = 0; f < 6; f++) begin
      d = DW'($urandom);
      send_frame(d, 1'($urandom), 5);
    end
    drain();

    // Back-to-back: second sof in the out_valid cycle
    vtimes.delete();
    send_frame(8'h81, 1'b0, 0);
    send_frame(8'h42, 1'b1, 0);
    drain();
    chk("b2b_pulses", vtimes.size(), 2);
    if (vtimes.size() == 2) chk("b2b_spacing", 32'(vtimes[1] - vtimes[0]), (DW + 1) * 10);

    // Asynchronous reset mid-frame
    for (int unsigned i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    #2 rst = 1'b1;
    #1;
    chk_zero("midrst");
    exp_cnt_e = 0; exp_cnt_o = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    @(negedge clk);
    chk("no_frame_across_rst", {ov_e, ov_o}, 0);
    send_frame(8'hFF, 1'b0, 0); drain();
    chk("ff_data", data_e, 8'hFF);
    chk("ff_perr_e", perr_e, 0);
    chk("ff_perr_o", perr_o, 1);

    // Saturation of the even-sense error counter
    for (int unsigned f = 0; f < 260; f++) begin
      d = DW'($urandom);
      send_frame(d, ~(^d), 0);
    end
    drain();
    chk("sat_cnt_e", cnt_e, 255);
    chk("sat_cnt_o", cnt_o, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial parity checker: the receive end of the parity-protected link whose transmitter builds its parity bit from XOR gates. It deserialises a frame of DATA_W data bits (LSB first) followed by one parity bit and presents the parallel word with a parity-error flag. It also pulses an abort flag and keeps a saturating error count. It sits between the serial line front end and the word-level consumer.

## Interface
- DATA_W, 8, data bits per frame, legal range 2..32
- ODD, 0, parity sense: 0 = even (total ones including parity bit even), 1 = odd
- CNT_W, 8, width of the error counter
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- bit_in  input  1  serial data/parity bit, sampled only when bit_valid=1
- bit_valid  input  1  bit_in is valid this cycle; gaps of any length between bits are allowed
- sof  input  1  qualifies bit_valid; marks this bit as data bit 0 of a new frame
- data_out  output  DATA_W  last completed frame's data word; holds until the next completion
- par_err  output  1  parity result of last completed frame; holds with data_out
- out_valid  output  1  one-cycle pulse: data_out/par_err updated
- frame_abort  output  1  one-cycle pulse: a frame in progress was discarded by a new sof
- err_count  output  CNT_W  number of frames completed with par_err=1, saturating

## Operation
- States:
  - IDLE: waiting for a start-of-frame bit.
  - DATA: collecting data bits.
  - PAR: waiting for the parity bit.
- IDLE: bit_valid&sof → shift_reg[0]=bit_in, acc=bit_in, cnt=1, go to DATA. bit_valid without sof is ignored.
- DATA: bit_valid&!sof → shift_reg[cnt]=bit_in, acc^=bit_in, cnt++. When cnt reaches DATA_W, go to PAR.
- PAR: bit_valid&!sof → parity bit p. On that edge: data_out=shift_reg, par_err=acc^p^ODD, out_valid=1, err_count+=par_err (held at 2^CNT_W−1 once reached), go to IDLE.
- sof in DATA or PAR (with bit_valid): frame_abort=1, discard partial frame, restart as in IDLE with this bit as bit 0, stay in/go to DATA. data_out, par_err and err_count are unchanged.
- sof without bit_valid has no effect in any state.
- Partial frames are never presented on data_out.

## Timing
- All outputs are registered.
- Reset values: data_out=0, par_err=0, out_valid=0, frame_abort=0, err_count=0. Internal state is IDLE, cnt=0, acc=0.
- Latency: out_valid is high in the cycle immediately after the edge that samples the parity bit.
- Back-to-back frames: a sof bit in the same cycle that out_valid is high is accepted (state is already IDLE). Zero dead cycles are required.
- Minimum frame duration is DATA_W+1 valid cycles.
- Reset asserted mid-frame clears everything immediately (asynchronous). A frame is never completed across reset.
- frame_abort and out_valid are never high in the same cycle.

## Structure
- Package parity_pkg:
  - state enum {IDLE, DATA, PAR}
  - constants PAR_EVEN=0 and PAR_ODD=1
- One natural sub-module: parity_acc, a 1-bit running XOR register with synchronous clear/load and asynchronous reset. It is instantiated once; the top holds the FSM, shift register, bit counter and error counter.

## Test plan
- DATA_W=8, ODD=0:
  - Send 0xA5 as bits 1,0,1,0,0,1,0,1 with p=0 → out_valid pulse one cycle later, data_out=0xA5, par_err=0, err_count=0.
  - Same frame with p=1 → data_out=0xA5, par_err=1, err_count=1.
- ODD=1: send 0x07 with p=0 → par_err=0. Send 0x07 with p=1 → par_err=1.
- Abort: send 4 bits of a frame, then sof with the 0x3C frame and correct even parity → frame_abort pulses once at the sof edge, then data_out=0x3C, par_err=0, err_count unchanged.
- Gaps and back-to-back:
  - Random 0–5 idle cycles between bits gives the same results as gap-free.
  - Two frames with the second sof in the out_valid cycle → two out_valid pulses exactly DATA_W+1 cycles apart.
- Reset and saturation:
  - Assert rst after 5 data bits → all outputs 0. The next full frame 0xFF, p=0 decodes correctly.
  - 260 bad-parity frames with CNT_W=8 → err_count stops at 255.
